// File: rtl/register_file_mp.sv
// Multi-port register file with write-port priority, same-cycle bypass,
// optional hardwired zero register and a per-register busy scoreboard.
module register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_DEPTH  = 32,
    parameter int NUM_READ   = 3,
    parameter int NUM_WRITE  = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                            clk,
    input  logic                            arst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  i_rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]  o_rd_data,
    output logic [NUM_READ-1:0]             o_rd_busy,
    input  logic [NUM_WRITE-1:0]            i_wr_en,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] i_wr_data,
    input  logic                            i_claim_en,
    input  logic [ADDR_WIDTH-1:0]           i_claim_addr
);

    // An address is usable when it maps to real storage and is not the hardwired zero.
    function automatic logic f_addr_ok(input logic [ADDR_WIDTH-1:0] addr);
        return (int'(addr) < REG_DEPTH) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    logic [DATA_WIDTH-1:0] r_regs [REG_DEPTH];
    logic [REG_DEPTH-1:0]  r_busy;
    logic [NUM_WRITE-1:0]  w_wr_ok;
    logic                  w_claim_ok;

    always_comb begin
        w_wr_ok = '0;
        for (int w = 0; w < NUM_WRITE; w++) begin
            w_wr_ok[w] = i_wr_en[w] && f_addr_ok(i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]);
        end
        w_claim_ok = i_claim_en && f_addr_ok(i_claim_addr);
    end

    // Ascending port loop: the last non-blocking update wins, so the highest port has priority.
    // The claim comes after the write clears so that a new producer keeps the register busy.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (w_wr_ok[w]) begin
                    r_regs[i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= i_wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                    r_busy[i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
                end
            end
            if (w_claim_ok) begin
                r_busy[i_claim_addr] <= 1'b1;
            end
        end
    end

    for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] w_data;
        logic                  w_busy;

        assign w_ra = i_rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (f_addr_ok(w_ra)) begin
                w_data = r_regs[w_ra];
                w_busy = r_busy[w_ra];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NUM_WRITE; w++) begin
                        if (w_wr_ok[w] && (i_wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == w_ra)) begin
                            w_data = i_wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                            // A claim in the same cycle is not bypassed; keep showing stored busy.
                            w_busy = (w_claim_ok && (i_claim_addr == w_ra)) ? r_busy[w_ra] : 1'b0;
                        end
                    end
                end
            end
        end

        assign o_rd_data[r*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign o_rd_busy[r]                          = w_busy;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: bypassing, non-bypassing and 24-deep instances
// share one stimulus stream; outputs are compared against hand-computed tables.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        arst;
    logic [14:0] rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;

    logic [95:0] rd_data_a, rd_data_n, rd_data_s;
    logic [2:0]  rd_busy_a, rd_busy_n, rd_busy_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    register_file_mp dut_a (
        .clk(clk), .arst(arst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_a), .o_rd_busy(rd_busy_a),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_claim_en(claim_en), .i_claim_addr(claim_addr)
    );

    register_file_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .arst(arst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n), .o_rd_busy(rd_busy_n),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_claim_en(claim_en), .i_claim_addr(claim_addr)
    );

    register_file_mp #(.REG_DEPTH(24)) dut_s (
        .clk(clk), .arst(arst), .i_rd_addr(rd_addr), .o_rd_data(rd_data_s), .o_rd_busy(rd_busy_s),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_claim_en(claim_en), .i_claim_addr(claim_addr)
    );

    typedef struct packed {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ce;
        logic [4:0]  ca;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [31:0] ed2;
        logic [2:0]  eb;
        logic [31:0] nd0;
        logic        nb0;
    } vec_t;

    vec_t vecs [19];
    logic [31:0] exp_s [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_wr();
        wr_en      = 2'b00;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
    endtask

    task automatic drive(input vec_t v);
        wr_en      = v.we;
        wr_addr    = {v.wa1, v.wa0};
        wr_data    = {v.wd1, v.wd0};
        claim_en   = v.ce;
        claim_addr = v.ca;
        rd_addr    = {v.ra2, v.ra1, v.ra0};
    endtask

    initial begin
        //          we     wa0    wd0            wa1    wd1           ce    ca     ra0    ra1    ra2    ed0            ed1            ed2            eb      nd0            nb0
        vecs[0]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd1,  5'd31, 32'h0,         32'h0,         32'h0,         3'b000, 32'h0,         1'b0};
        vecs[1]  = '{2'b11, 5'd5,  32'h100,      5'd6,  32'h200,      1'b0, 5'd0,  5'd5,  5'd6,  5'd7,  32'h100,       32'h200,       32'h0,         3'b000, 32'h0,         1'b0};
        vecs[2]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd6,  5'd0,  32'h100,       32'h200,       32'h0,         3'b000, 32'h100,       1'b0};
        vecs[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  5'd5,  32'h0,         32'h0,         32'h100,       3'b000, 32'h0,         1'b0};
        vecs[4]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd5,  5'd6,  32'h0,         32'h100,       32'h200,       3'b001, 32'h0,         1'b1};
        vecs[5]  = '{2'b01, 5'd9,  32'h77,       5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  5'd9,  32'h77,        32'h77,        32'h77,        3'b000, 32'h0,         1'b1};
        vecs[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  5'd9,  32'h77,        32'h77,        32'h77,        3'b000, 32'h77,        1'b0};
        vecs[7]  = '{2'b10, 5'd0,  32'h0,        5'd9,  32'h88,       1'b1, 5'd9,  5'd9,  5'd9,  5'd9,  32'h88,        32'h88,        32'h88,        3'b000, 32'h77,        1'b0};
        vecs[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  5'd9,  32'h88,        32'h88,        32'h88,        3'b111, 32'h88,        1'b1};
        vecs[9]  = '{2'b11, 5'd7,  32'hAAAA0000, 5'd7,  32'h5555FFFF, 1'b0, 5'd0,  5'd7,  5'd7,  5'd9,  32'h5555FFFF,  32'h5555FFFF,  32'h88,        3'b100, 32'h0,         1'b0};
        vecs[10] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  5'd7,  32'h5555FFFF,  32'h5555FFFF,  32'h5555FFFF,  3'b000, 32'h5555FFFF,  1'b0};
        vecs[11] = '{2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         3'b000, 32'h0,         1'b0};
        vecs[12] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd9,  5'd7,  32'h0,         32'h88,        32'h5555FFFF,  3'b010, 32'h0,         1'b0};
        vecs[13] = '{2'b01, 5'd3,  32'h11,       5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  5'd3,  32'h11,        32'h11,        32'h11,        3'b000, 32'h0,         1'b0};
        vecs[14] = '{2'b10, 5'd0,  32'h0,        5'd3,  32'h22,       1'b0, 5'd0,  5'd3,  5'd3,  5'd3,  32'h22,        32'h22,        32'h22,        3'b000, 32'h11,        1'b0};
        vecs[15] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  5'd3,  32'h22,        32'h22,        32'h22,        3'b000, 32'h22,        1'b0};
        vecs[16] = '{2'b11, 5'd10, 32'h1,        5'd11, 32'h2,        1'b0, 5'd0,  5'd10, 5'd11, 5'd9,  32'h1,         32'h2,         32'h88,        3'b100, 32'h0,         1'b0};
        vecs[17] = '{2'b01, 5'd9,  32'h99,       5'd9,  32'hDEAD,     1'b0, 5'd0,  5'd9,  5'd9,  5'd9,  32'h99,        32'h99,        32'h99,        3'b000, 32'h88,        1'b1};
        vecs[18] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd10, 5'd11, 32'h99,        32'h1,         32'h2,         3'b000, 32'h99,        1'b0};

        for (int i = 0; i < 24; i++) exp_s[i] = 32'h0;
        exp_s[3]  = 32'h22;
        exp_s[5]  = 32'h100;
        exp_s[6]  = 32'h200;
        exp_s[7]  = 32'h5555FFFF;
        exp_s[9]  = 32'h99;
        exp_s[10] = 32'h1;
        exp_s[11] = 32'h2;

        arst    = 1'b1;
        rd_addr = '0;
        clear_wr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d data0", i), rd_data_a[31:0],  vecs[i].ed0);
            check($sformatf("v%0d data1", i), rd_data_a[63:32], vecs[i].ed1);
            check($sformatf("v%0d data2", i), rd_data_a[95:64], vecs[i].ed2);
            check($sformatf("v%0d busy", i),  {29'h0, rd_busy_a}, {29'h0, vecs[i].eb});
            check($sformatf("v%0d nobyp data0", i), rd_data_n[31:0], vecs[i].nd0);
            check($sformatf("v%0d nobyp busy0", i), {31'h0, rd_busy_n[0]}, {31'h0, vecs[i].nb0});
            @(posedge clk);
            #1;
        end

        // Out-of-range write and claim on the 24-deep instance.
        wr_en      = 2'b01;
        wr_addr    = {5'd0, 5'd30};
        wr_data    = {32'h0, 32'hFF};
        claim_en   = 1'b1;
        claim_addr = 5'd30;
        rd_addr    = {5'd30, 5'd30, 5'd30};
        @(negedge clk);
        check("oor same-cycle data", rd_data_s[31:0], 32'h0);
        check("oor same-cycle busy", {29'h0, rd_busy_s}, 32'h0);
        @(posedge clk);
        #1;
        clear_wr();
        @(negedge clk);
        check("oor next-cycle data", rd_data_s[31:0], 32'h0);
        check("oor next-cycle busy", {29'h0, rd_busy_s}, 32'h0);
        for (int i = 0; i < 24; i += 3) begin
            rd_addr = {5'(i + 2), 5'(i + 1), 5'(i)};
            #1;
            check($sformatf("depth24 r%0d", i),     rd_data_s[31:0],  exp_s[i]);
            check($sformatf("depth24 r%0d", i + 1), rd_data_s[63:32], exp_s[i + 1]);
            check($sformatf("depth24 r%0d", i + 2), rd_data_s[95:64], exp_s[i + 2]);
        end
        @(posedge clk);
        #1;

        // Mid-cycle asynchronous reset, then a write and claim presented while reset is held.
        wr_en      = 2'b01;
        wr_addr    = {5'd0, 5'd5};
        wr_data    = {32'h0, 32'hDEADBEEF};
        claim_en   = 1'b1;
        claim_addr = 5'd12;
        rd_addr    = {5'd5, 5'd12, 5'd5};
        @(posedge clk);
        #1;
        clear_wr();
        #1;
        check("pre-reset data r5",  rd_data_a[31:0], 32'hDEADBEEF);
        check("pre-reset busy r12", {31'h0, rd_busy_a[1]}, 32'h1);
        #1;
        arst = 1'b1;
        #1;
        check("reset byp data r5",   rd_data_a[31:0], 32'h0);
        check("reset nobyp data r5", rd_data_n[31:0], 32'h0);
        check("reset d24 data r5",   rd_data_s[31:0], 32'h0);
        check("reset byp busy",      {29'h0, rd_busy_a}, 32'h0);
        check("reset nobyp busy",    {29'h0, rd_busy_n}, 32'h0);
        check("reset d24 busy",      {29'h0, rd_busy_s}, 32'h0);
        wr_en      = 2'b01;
        wr_addr    = {5'd0, 5'd5};
        wr_data    = {32'h0, 32'h5};
        claim_en   = 1'b1;
        claim_addr = 5'd12;
        @(posedge clk);
        #1;
        clear_wr();
        @(negedge clk);
        arst = 1'b0;
        #1;
        check("post-reset data r5",  rd_data_n[31:0], 32'h0);
        check("post-reset busy r12", {31'h0, rd_busy_n[1]}, 32'h0);
        check("post-reset byp busy", {29'h0, rd_busy_a}, 32'h0);

        @(posedge clk);
        #1;
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'h0, 32'h42};
        @(posedge clk);
        #1;
        clear_wr();
        @(negedge clk);
        check("after reset write r5", rd_data_n[31:0], 32'h42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
